// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache, 8 lines x 4 bytes
module dcache_controller (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        read_i,
    input  logic        write_i,
    input  logic [7:0]  address_i,
    input  logic [7:0]  writedata_i,
    output logic [7:0]  readdata_o,
    output logic        busywait_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [5:0]  mem_address_o,
    output logic [31:0] mem_writedata_o,
    input  logic [31:0] mem_readdata_i,
    input  logic        mem_busywait_i,
    output logic [7:0]  hit_count_o,
    output logic [7:0]  miss_count_o
);
    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;
    state_t      state_q;
    logic [7:0]  valid_q, dirty_q;
    logic [2:0]  tag_q [8];
    logic [31:0] data_q [8];
    logic [7:0]  hit_cnt_q, miss_cnt_q;
    logic [2:0]  tag, idx;
    logic [1:0]  off;
    logic        req, hit;
    assign tag = address_i[7:5];
    assign idx = address_i[4:2];
    assign off = address_i[1:0];
    assign req = read_i | write_i;
    assign hit = valid_q[idx] && tag_q[idx] == tag;
    // Outputs decode from the state register; the miss stall is raised in the
    // request cycle itself, and reset forces the stall low without a clock edge.
    assign readdata_o      = hit ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;
    assign busywait_o      = rst_ni && (state_q != IDLE || (req && !hit));
    assign mem_write_o     = state_q == WRITEBACK;
    assign mem_read_o      = state_q == FETCH;
    assign mem_address_o   = mem_write_o ? {tag_q[idx], idx} : mem_read_o ? {tag, idx} : 6'h00;
    assign mem_writedata_o = mem_write_o ? data_q[idx] : 32'h0;
    assign hit_count_o     = hit_cnt_q;
    assign miss_count_o    = miss_cnt_q;
    // Miss sequencing, line status bits and saturating hit/miss counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    if (hit) begin
                        if (write_i) dirty_q[idx] <= 1'b1;
                        if (hit_cnt_q != 8'hFF) hit_cnt_q <= hit_cnt_q + 8'd1;
                    end else begin
                        if (miss_cnt_q != 8'hFF) miss_cnt_q <= miss_cnt_q + 8'd1;
                        state_q <= (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
                    end
                end
                WRITEBACK: if (!mem_busywait_i) state_q <= FETCH;
                FETCH: if (!mem_busywait_i) state_q <= UPDATE;
                UPDATE: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Line data and tags are never cleared; valid bits alone decide whether they count
    always_ff @(posedge clk_i) begin
        if (state_q == FETCH && !mem_busywait_i) data_q[idx] <= mem_readdata_i;
        if (state_q == IDLE && write_i && hit) data_q[idx][{off, 3'b000} +: 8] <= writedata_i;
        if (state_q == UPDATE) tag_q[idx] <= tag;
    end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed scoreboard bench for dcache_controller with a latency-programmable block memory
module tb_dcache_controller;
    logic        clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [7:0]  addr = 8'h00, wdata = 8'h00;
    logic [7:0]  readdata, hit_count, miss_count;
    logic        busywait, mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
    logic [31:0] mem [64];
    int          cnt = 0, lat = 1, checks = 0, failures = 0;
    int          nr = 0, nw = 0, overlap = 0, st = 0, n0r = 0, n0w = 0;
    logic [5:0]  wb_addr = 6'h00, rd_addr = 6'h00;
    logic [31:0] wb_data = 32'h0;
    logic [7:0]  q [$];

    dcache_controller dut (
        .clk_i(clk), .rst_ni(rst_n), .read_i(rd), .write_i(wr),
        .address_i(addr), .writedata_i(wdata), .readdata_o(readdata),
        .busywait_o(busywait), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_address_o(mem_address), .mem_writedata_o(mem_writedata),
        .mem_readdata_i(mem_readdata), .mem_busywait_i(mem_busywait),
        .hit_count_o(hit_count), .miss_count_o(miss_count)
    );

    always #5 clk = ~clk;

    // Memory raises busy as soon as a request appears and drops it for the lat+1-th cycle
    assign mem_busywait = (mem_read || mem_write) && (cnt != lat);
    assign mem_readdata = mem[mem_address];

    function automatic logic [7:0] mv(input logic [7:0] a);
        return a ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task mem_model;
        forever @(posedge clk) begin
            if (mem_read || mem_write) begin
                if (cnt == lat) begin
                    cnt <= 0;
                    if (mem_write) mem[mem_address] <= mem_writedata;
                end else cnt <= cnt + 1;
            end else cnt <= 0;
        end
    endtask

    // Pops one expected load value each time the DUT completes a read (READ high, no stall)
    task monitor;
        logic [7:0] e;
        forever @(negedge clk) begin
            if (mem_read && mem_write) overlap++;
            if (mem_write) begin nw++; wb_addr = mem_address; wb_data = mem_writedata; end
            if (mem_read) begin nr++; rd_addr = mem_address; end
            if (rst_n && rd && !wr && !busywait) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got readdata %0h with no expectation queued", readdata);
                end else begin
                    e = q.pop_front();
                    check("sb_readdata", 32'(readdata), 32'(e));
                end
            end
        end
    endtask

    task automatic wait_ready(output int stalls);
        int n = 0;
        stalls = 0;
        @(negedge clk);
        while (busywait && n < 200) begin
            stalls++;
            n++;
            @(negedge clk);
        end
        if (busywait) begin
            checks++;
            failures++;
            $display("FAIL access_timeout: busywait still 1 after %0d cycles, required 0", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, output int stalls);
        q.push_back(exp);
        addr = a;
        rd = 1'b1;
        wait_ready(stalls);
        rd = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        int s;
        addr = a;
        wdata = d;
        wr = 1'b1;
        wait_ready(s);
        wr = 1'b0;
    endtask

    task automatic mark;
        n0r = nr;
        n0w = nw;
    endtask

    initial begin
        int n;
        for (int b = 0; b < 64; b++)
            mem[b] = {mv(8'(b*4+3)), mv(8'(b*4+2)), mv(8'(b*4+1)), mv(8'(b*4))};
        fork
            mem_model();
            monitor();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check("rst_busywait", 32'(busywait), 0);
        check("rst_mem_read", 32'(mem_read), 0);
        check("rst_mem_write", 32'(mem_write), 0);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_writedata", mem_writedata, 0);
        check("rst_readdata", 32'(readdata), 0);
        check("rst_hit_count", 32'(hit_count), 0);
        check("rst_miss_count", 32'(miss_count), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Cold read of 0x03: clean miss, fetch block 0, replay as a hit
        mark();
        do_read(8'h03, mv(8'h03), st);
        check("t1_stall", 32'(st), 4);
        check("t1_miss_count", 32'(miss_count), 1);
        check("t1_hit_count", 32'(hit_count), 1);
        check("t1_mem_read_cycles", 32'(nr - n0r), 2);
        check("t1_mem_read_addr", 32'(rd_addr), 32'h00);
        check("t1_mem_write_cycles", 32'(nw - n0w), 0);
        // Write hit then read-back hit, no memory traffic
        mark();
        do_write(8'h03, 8'h0A);
        do_read(8'h03, 8'h0A, st);
        check("t2_stall", 32'(st), 0);
        check("t2_mem_cycles", 32'(nr - n0r + nw - n0w), 0);
        check("t2_dirty0", 32'(dut.dirty_q[0]), 1);
        check("t2_hit_count", 32'(hit_count), 3);
        // Dirty eviction of line 0 by 0x23
        mark();
        do_read(8'h23, mv(8'h23), st);
        check("t3_wb_cycles", 32'(nw - n0w), 2);
        check("t3_wb_addr", 32'(wb_addr), 32'h00);
        check("t3_wb_byte3", 32'(wb_data[31:24]), 32'h0A);
        check("t3_wb_byte0", 32'(wb_data[7:0]), 32'(mv(8'h00)));
        check("t3_fetch_cycles", 32'(nr - n0r), 2);
        check("t3_fetch_addr", 32'(rd_addr), 32'h08);
        check("t3_overlap", 32'(overlap), 0);
        check("t3_miss_count", 32'(miss_count), 2);
        // Clean miss with 5 busy cycles: stall of 7 after the miss cycle
        lat = 5;
        do_read(8'h65, mv(8'h65), st);
        check("t4_stall_after_miss", 32'(st - 1), 7);
        check("t4_miss_count", 32'(miss_count), 3);
        // Reset asserted mid-fetch
        lat = 10;
        addr = 8'h88;
        rd = 1'b1;
        n = 0;
        @(negedge clk);
        while (!mem_read && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("t5_reached_fetch", 32'(mem_read), 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_mem_read_async", 32'(mem_read), 0);
        check("t5_busywait_async", 32'(busywait), 0);
        check("t5_valid2", 32'(dut.valid_q[2]), 0);
        rd = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        lat = 1;
        @(posedge clk);
        #1;
        do_read(8'h88, mv(8'h88), st);
        check("t5_reread_stall", 32'(st), 4);
        check("t5_reread_miss_count", 32'(miss_count), 1);
        // One fill then 300 hits: hit counter saturates
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_read(8'h00, mv(8'h00), st);
        for (int i = 0; i < 300; i++) do_read(8'h00, mv(8'h00), st);
        check("t6_hit_saturated", 32'(hit_count), 255);
        check("t6_miss_count", 32'(miss_count), 1);
        check("t6_overlap", 32'(overlap), 0);
        check("sb_drained", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the 8-bit CPU's load/store path (`lwi`/`swi`/`lwd`/`swd`) and the block-organised data memory. The CPU sees byte reads and writes. The memory sees 4-byte block transfers. The controller stalls the CPU through BUSYWAIT on a miss and sequences the write-back and fetch transactions. It also keeps saturating hit and miss counters for the test benches.

## Interface
- Parameters: none. Geometry is fixed at 8 lines × 4 bytes and an 8-bit address (tag[7:5], index[4:2], offset[1:0]).
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU byte read request.
- WRITE  in  1  CPU byte write request.
- ADDRESS  in  8  CPU byte address.
- WRITEDATA  in  8  CPU store data.
- READDATA  out  8  CPU load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory block read request.
- MEM_WRITE  out  1  memory block write request.
- MEM_ADDRESS  out  6  memory block address {tag,index}.
- MEM_WRITEDATA  out  32  block to memory; byte 0 is in [7:0].
- MEM_READDATA  in  32  block from memory; byte 0 is in [7:0].
- MEM_BUSYWAIT  in  1  memory busy.
- HIT_COUNT  out  8  saturating count of completed hit accesses.
- MISS_COUNT  out  8  saturating count of misses.

## Operation
- Storage: 8 lines, each holding valid, dirty, a 3-bit tag and 32 bits of data.
- hit = valid[index] && tag[index] == ADDRESS[7:5]. This is combinational.
- Request = READ | WRITE. If READ and WRITE are both high, the access is treated as a write.
- FSM states are IDLE, WRITEBACK, FETCH and UPDATE.
- IDLE, no request: BUSYWAIT = 0.
- IDLE, request and hit: BUSYWAIT = 0.
  - Read: READDATA = the selected byte of the line, combinationally.
  - Write: at the rising edge, write WRITEDATA into the byte at the offset and set dirty. Increment HIT_COUNT.
- IDLE, request and miss: BUSYWAIT = 1 combinationally. Increment MISS_COUNT at the edge.
  - If the line is valid and dirty, go to WRITEBACK. Otherwise go to FETCH.
- WRITEBACK: MEM_WRITE = 1, MEM_ADDRESS = {stored tag, index}, MEM_WRITEDATA = line data.
  - Go to FETCH at the first edge where MEM_BUSYWAIT is sampled 0.
- FETCH: MEM_READ = 1, MEM_ADDRESS = {ADDRESS[7:5], index}.
  - Go to UPDATE at the first edge where MEM_BUSYWAIT is sampled 0. The line is loaded from MEM_READDATA at that same edge.
- UPDATE: set valid, clear dirty, write the tag. BUSYWAIT stays 1. Go to IDLE.
  - The access then replays in IDLE as a hit. That hit increments HIT_COUNT.
- BUSYWAIT = 1 in every non-IDLE state.
- MEM_READ and MEM_WRITE are never both high. Both are 0 in IDLE and UPDATE.
- Memory contract: MEM_BUSYWAIT goes high combinationally in the same cycle a request appears. It drops for the completing cycle.
- The CPU holds ADDRESS, READ, WRITE and WRITEDATA stable while BUSYWAIT = 1.
- HIT_COUNT and MISS_COUNT saturate at 255 and do not wrap.

## Timing
- Reset (RESET = 0, any time, asynchronous):
  - State goes to IDLE. All valid and dirty bits clear. Both counters are 0.
  - MEM_READ, MEM_WRITE and BUSYWAIT are 0.
  - MEM_ADDRESS, MEM_WRITEDATA and READDATA are 0.
  - The line data array is not cleared.
- Reset mid-miss: the request deasserts immediately and the partial fetch is discarded. The line stays invalid.
- Hit latency: 0 stall cycles.
- Clean miss: FETCH for N+1 cycles, where N is the number of memory busy cycles, then UPDATE, then a hit in IDLE.
  - Stall = N+2 cycles after the miss cycle.
- Dirty miss: adds WRITEBACK for M+1 cycles before FETCH.
- Request deasserted during WRITEBACK, FETCH or UPDATE: the sequence still completes and the line fill takes effect.
- A new request in the cycle after BUSYWAIT falls is serviced normally.

## Test plan
- Reset, then read 0x03.
  - Required: MISS_COUNT = 1 and MEM_READ for block 0x00 with no MEM_WRITE.
  - Then READDATA = byte 3 of MEM_READDATA and HIT_COUNT = 1.
- Write 0x0A to 0x03, then read 0x03.
  - Required: the read is a hit with no MEM_* activity, READDATA = 0x0A, and dirty[0] = 1.
- Dirty eviction: after the previous case, read 0x23, which has the same index and a different tag.
  - Required: MEM_WRITE with MEM_ADDRESS = 0x00 and MEM_WRITEDATA[31:24] = 0x0A.
  - Then MEM_READ with MEM_ADDRESS = 0x08. MEM_READ and MEM_WRITE are never high together.
- Memory busy for 5 cycles on a clean miss.
  - Required: BUSYWAIT is high for exactly 7 cycles after the miss cycle.
- Pull RESET low during FETCH.
  - Required: MEM_READ and BUSYWAIT go to 0 without waiting for a clock edge, and valid[index] = 0.
  - A re-read of the same address misses again.
- Run 300 reads of 0x00 after one fill.
  - Required: HIT_COUNT = 255 (saturated) and MISS_COUNT = 1.
